// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - request/result and divider-IP stream signals of div_ctrl
// slave = controller side, master = EX stage plus the two divider IPs.
interface div_ctrl_if #(
    parameter int DW = 32
);
    logic            req_valid;
    logic            req_signed;
    logic            req_mod;
    logic [DW-1:0]   req_src1;
    logic [DW-1:0]   req_src2;
    logic            req_ready;
    logic            cancel;
    logic            done;
    logic            res_ack;
    logic [DW-1:0]   result;
    logic            busy;

    logic [DW-1:0]   dividend_tdata;
    logic [DW-1:0]   divisor_tdata;

    logic            s_dividend_tvalid;
    logic            s_divisor_tvalid;
    logic            s_dividend_tready;
    logic            s_divisor_tready;
    logic            s_dout_tvalid;
    logic [2*DW-1:0] s_dout_tdata;

    logic            u_dividend_tvalid;
    logic            u_divisor_tvalid;
    logic            u_dividend_tready;
    logic            u_divisor_tready;
    logic            u_dout_tvalid;
    logic [2*DW-1:0] u_dout_tdata;

    modport slave (
        input  req_valid, req_signed, req_mod, req_src1, req_src2, cancel, res_ack,
        input  s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
        input  u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata,
        output req_ready, done, result, busy, dividend_tdata, divisor_tdata,
        output s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid
    );

    modport master (
        output req_valid, req_signed, req_mod, req_src1, req_src2, cancel, res_ack,
        output s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
        output u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata,
        input  req_ready, done, result, busy, dividend_tdata, divisor_tdata,
        input  s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid
    );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequences div/mod ops onto a signed or unsigned divider IP
// Optional macro DIV_ZERO_FAST_EN: zero divisors complete directly without the IP.
module div_ctrl #(
    parameter int DW       = 32,
    parameter bit DOUT_QHI = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    div_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

    state_t          state;
    state_t          state_nx;

    logic [DW-1:0]   src1_q;
    logic [DW-1:0]   src2_q;
    logic [DW-1:0]   result_q;
    logic            sgn_q;
    logic            mod_q;
    logic            kill_flag;
    logic            dvd_done;
    logic            dvs_done;

    logic            dvd_tready;
    logic            dvs_tready;
    logic            dout_tvalid;
    logic [2*DW-1:0] dout_tdata;
    logic            dvd_pend;
    logic            dvs_pend;
    logic            dvd_hs;
    logic            dvs_hs;
    logic            issue_done;
    logic            accept;
    logic            fast_zero;
    logic            latch_res;
    logic [DW-1:0]   quo;
    logic [DW-1:0]   rem;

    // Only the IP chosen by the latched signed bit is ever looked at.
    assign dvd_tready  = sgn_q ? bus.s_dividend_tready : bus.u_dividend_tready;
    assign dvs_tready  = sgn_q ? bus.s_divisor_tready  : bus.u_divisor_tready;
    assign dout_tvalid = sgn_q ? bus.s_dout_tvalid     : bus.u_dout_tvalid;
    assign dout_tdata  = sgn_q ? bus.s_dout_tdata      : bus.u_dout_tdata;

    assign dvd_pend   = (state == ISSUE) && !dvd_done;
    assign dvs_pend   = (state == ISSUE) && !dvs_done;
    assign dvd_hs     = dvd_pend && dvd_tready;
    assign dvs_hs     = dvs_pend && dvs_tready;
    assign issue_done = (dvd_done || dvd_hs) && (dvs_done || dvs_hs);
    assign accept     = (state == IDLE) && bus.req_valid && !bus.cancel;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = accept && (bus.req_src2 == '0);
`else
    assign fast_zero = 1'b0;
`endif

    assign quo = DOUT_QHI ? dout_tdata[2*DW-1:DW] : dout_tdata[DW-1:0];
    assign rem = DOUT_QHI ? dout_tdata[DW-1:0]    : dout_tdata[2*DW-1:DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        latch_res = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = fast_zero ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue_done) begin
                    state_nx = (kill_flag || bus.cancel) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                // A result arriving together with cancel is already drained.
                if (bus.cancel) begin
                    state_nx = dout_tvalid ? IDLE : DRAIN;
                end else if (dout_tvalid) begin
                    state_nx  = DONE;
                    latch_res = 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ack || bus.cancel) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (dout_tvalid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src1_q    <= '0;
            src2_q    <= '0;
            sgn_q     <= 1'b0;
            mod_q     <= 1'b0;
            kill_flag <= 1'b0;
            dvd_done  <= 1'b0;
            dvs_done  <= 1'b0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                src1_q    <= bus.req_src1;
                src2_q    <= bus.req_src2;
                sgn_q     <= bus.req_signed;
                mod_q     <= bus.req_mod;
                kill_flag <= 1'b0;
                dvd_done  <= 1'b0;
                dvs_done  <= 1'b0;
            end
            if (dvd_hs) begin
                dvd_done <= 1'b1;
            end
            if (dvs_hs) begin
                dvs_done <= 1'b1;
            end
            if ((state == ISSUE) && bus.cancel) begin
                kill_flag <= 1'b1;
            end
            if (latch_res) begin
                result_q <= mod_q ? rem : quo;
            end
`ifdef DIV_ZERO_FAST_EN
            if (fast_zero) begin
                result_q <= bus.req_mod ? bus.req_src1 : '1;
            end
`endif
        end
    end

    assign bus.req_ready         = (state == IDLE);
    assign bus.busy              = (state != IDLE);
    assign bus.done              = (state == DONE);
    assign bus.result            = result_q;
    assign bus.dividend_tdata    = src1_q;
    assign bus.divisor_tdata     = src2_q;
    assign bus.s_dividend_tvalid = dvd_pend && sgn_q;
    assign bus.s_divisor_tvalid  = dvs_pend && sgn_q;
    assign bus.u_dividend_tvalid = dvd_pend && !sgn_q;
    assign bus.u_divisor_tvalid  = dvs_pend && !sgn_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with directed vectors
// Optional macro DIV_ZERO_FAST_EN selects the zero-divisor expectations.
module tb_div_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_ctrl_if #(.DW(DW)) bus ();

    div_ctrl #(.DW(DW), .DOUT_QHI(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    logic          done_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising done must match the oldest expected result.
    always @(negedge clk) begin
        if (bus.done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got result 0x%0h, want no done", bus.result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", bus.result, mon_exp);
            end
        end
        done_d = bus.done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic sgn, input logic md, input logic [DW-1:0] a,
                            input logic [DW-1:0] b);
        bus.req_valid  = 1'b1;
        bus.req_signed = sgn;
        bus.req_mod    = md;
        bus.req_src1   = a;
        bus.req_src2   = b;
    endtask

    task automatic set_tready(input logic s, input logic u);
        bus.s_dividend_tready = s;
        bus.s_divisor_tready  = s;
        bus.u_dividend_tready = u;
        bus.u_divisor_tready  = u;
    endtask

    task automatic pulse_s(input logic [2*DW-1:0] d);
        bus.s_dout_tvalid = 1'b1;
        bus.s_dout_tdata  = d;
        step();
        bus.s_dout_tvalid = 1'b0;
    endtask

    task automatic pulse_u(input logic [2*DW-1:0] d);
        bus.u_dout_tvalid = 1'b1;
        bus.u_dout_tdata  = d;
        step();
        bus.u_dout_tvalid = 1'b0;
    endtask

    task automatic ack();
        bus.res_ack = 1'b1;
        step();
        bus.res_ack = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            step();
            n++;
        end
        check("done_within_budget", bus.done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_mod    = 1'b0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.cancel     = 1'b0;
        bus.res_ack    = 1'b0;
        bus.s_dout_tvalid = 1'b0;
        bus.u_dout_tvalid = 1'b0;
        bus.s_dout_tdata  = '0;
        bus.u_dout_tdata  = '0;
        set_tready(1'b0, 1'b0);
        step();
        step();

        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", bus.result, 32'h0);
        check("rst_dividend_tdata", bus.dividend_tdata, 32'h0);
        check("rst_divisor_tdata", bus.divisor_tdata, 32'h0);
        check("rst_tvalid", {bus.s_dividend_tvalid, bus.s_divisor_tvalid,
                             bus.u_dividend_tvalid, bus.u_divisor_tvalid}, 4'b0000);
        reset = 1'b0;

        // Signed div -7 / 2, accepted on the first edge after reset release.
        set_tready(1'b1, 1'b0);
        send_req(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        exp_q.push_back(32'hFFFF_FFFD);
        step();
        bus.req_valid = 1'b0;
        check("sdiv_busy", bus.busy, 1'b1);
        check("sdiv_req_ready", bus.req_ready, 1'b0);
        check("sdiv_s_tvalid", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}, 2'b11);
        check("sdiv_u_tvalid", {bus.u_dividend_tvalid, bus.u_divisor_tvalid}, 2'b00);
        check("sdiv_dividend_tdata", bus.dividend_tdata, 32'hFFFF_FFF9);
        step();
        check("sdiv_tvalid_dropped", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}, 2'b00);
        bus.s_dout_tvalid = 1'b1;
        bus.s_dout_tdata  = {32'hFFFF_FFFD, 32'hFFFF_FFFF};
        check("sdiv_no_early_done", bus.done, 1'b0);
        step();
        bus.s_dout_tvalid = 1'b0;
        check("sdiv_done", bus.done, 1'b1);
        step();
        step();
        check("sdiv_result_held", bus.result, 32'hFFFF_FFFD);
        check("sdiv_done_held", bus.done, 1'b1);
        ack();
        check("sdiv_ready_after_ack", bus.req_ready, 1'b1);
        check("sdiv_done_cleared", bus.done, 1'b0);

        // Unsigned mod 100 % 7, back-to-back with the ack, divisor tready late.
        set_tready(1'b0, 1'b0);
        bus.u_dividend_tready = 1'b1;
        send_req(1'b0, 1'b1, 32'd100, 32'd7);
        exp_q.push_back(32'd2);
        step();
        bus.req_valid = 1'b0;
        check("umod_accepted", bus.busy, 1'b1);
        check("umod_u_tvalid", {bus.u_dividend_tvalid, bus.u_divisor_tvalid}, 2'b11);
        check("umod_s_tvalid", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}, 2'b00);
        step();
        check("umod_dvd_dropped", {bus.u_dividend_tvalid, bus.u_divisor_tvalid}, 2'b01);
        step();
        step();
        check("umod_dvs_held", bus.u_divisor_tvalid, 1'b1);
        check("umod_dvs_tdata", bus.divisor_tdata, 32'd7);
        bus.u_divisor_tready = 1'b1;
        step();
        bus.u_divisor_tready = 1'b0;
        check("umod_dvs_dropped", bus.u_divisor_tvalid, 1'b0);
        pulse_s({32'd99, 32'd99});
        check("umod_ignore_other_ip", bus.done, 1'b0);
        pulse_u({32'd14, 32'd2});
        wait_done(4);
        ack();

        // Cancel in WAIT, new request held during DRAIN.
        set_tready(1'b1, 1'b1);
        send_req(1'b1, 1'b0, 32'd20, 32'd3);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        send_req(1'b0, 1'b0, 32'd50, 32'd5);
        step();
        check("drain_req_ready", bus.req_ready, 1'b0);
        check("drain_busy", bus.busy, 1'b1);
        step();
        check("drain_not_accepted", bus.u_dividend_tvalid, 1'b0);
        pulse_s({32'd6, 32'd2});
        check("drain_to_idle", bus.req_ready, 1'b1);
        exp_q.push_back(32'd10);
        step();
        bus.req_valid = 1'b0;
        check("after_drain_issue", bus.u_dividend_tvalid, 1'b1);
        step();
        pulse_u({32'd10, 32'd0});
        wait_done(4);
        ack();

        // Cancel in ISSUE with both treadys low.
        set_tready(1'b0, 1'b0);
        send_req(1'b1, 1'b0, 32'h0000_0032, 32'd7);
        step();
        bus.req_valid = 1'b0;
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        check("issue_cancel_tvalid", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}, 2'b11);
        step();
        check("issue_cancel_tvalid_held", {bus.s_dividend_tvalid, bus.s_divisor_tvalid}, 2'b11);
        check("issue_cancel_tdata", {bus.dividend_tdata, bus.divisor_tdata}, {32'h32, 32'd7});
        set_tready(1'b1, 1'b0);
        step();
        set_tready(1'b0, 1'b0);
        check("issue_cancel_drain", {bus.busy, bus.s_dividend_tvalid, bus.done}, 3'b100);
        pulse_s({32'd7, 32'd1});
        check("issue_cancel_idle", bus.req_ready, 1'b1);

        // Cancel and dout_tvalid together in WAIT.
        set_tready(1'b1, 1'b0);
        send_req(1'b1, 1'b0, 32'd9, 32'd3);
        step();
        bus.req_valid = 1'b0;
        step();
        bus.cancel = 1'b1;
        pulse_s({32'd3, 32'd0});
        bus.cancel = 1'b0;
        check("wait_cancel_dout_idle", bus.req_ready, 1'b1);

        // Cancel alongside req_valid in IDLE.
        send_req(1'b0, 1'b0, 32'd8, 32'd2);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        bus.req_valid = 1'b0;
        check("idle_cancel_not_accepted", bus.busy, 1'b0);

        // Reset asserted in WAIT, then a stale dout pulse.
        send_req(1'b1, 1'b0, 32'd40, 32'd4);
        step();
        bus.req_valid = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_idle", {bus.busy, bus.req_ready}, 2'b01);
        step();
        reset = 1'b0;
        pulse_s({32'd10, 32'd0});
        check("stale_dout_ignored", {bus.done, bus.req_ready}, 2'b01);

        // Zero divisor mod.
        set_tready(1'b0, 1'b1);
        send_req(1'b0, 1'b1, 32'h1234_5678, 32'd0);
        exp_q.push_back(32'h1234_5678);
        step();
        bus.req_valid = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        check("zero_fast_done", bus.done, 1'b1);
        check("zero_fast_no_tvalid", {bus.u_dividend_tvalid, bus.u_divisor_tvalid}, 2'b00);
`else
        check("zero_slow_tvalid", {bus.u_dividend_tvalid, bus.u_divisor_tvalid}, 2'b11);
        check("zero_slow_no_done", bus.done, 1'b0);
        step();
        pulse_u({32'hFFFF_FFFF, 32'h1234_5678});
`endif
        wait_done(4);
        ack();
        set_tready(1'b0, 1'b0);

        step();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: DW, 32, operand width; dout width is 2*DW.
REQ-002 Parameter: DOUT_QHI, 1, 1 = quotient in dout[2DW-1:DW] and remainder in dout[DW-1:0]; 0 = swapped.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  EX stage has a div/mod op; req_signed  in  1  1 = div.w/mod.w, 0 = div.wu/mod.wu; req_mod  in  1  1 = remainder wanted.
REQ-007 req_src1 / req_src2  in  DW  dividend / divisor; req_ready  out  1  controller idle, can accept.
REQ-008 cancel  in  1  exception flush; kills the current or incoming op.
REQ-009 done  out  1  result valid; res_ack  in  1  EX consumes result (es_allowin); result  out  DW  selected quotient or remainder.
REQ-010 busy  out  1  state != IDLE.
REQ-011 dividend_tdata / divisor_tdata  out  DW  latched operands, shared by both divider IPs.
REQ-012 s_dividend_tvalid, s_divisor_tvalid  out  1; s_dividend_tready, s_divisor_tready  in  1; s_dout_tvalid  in  1; s_dout_tdata  in  2DW: signed divider IP port set.
REQ-013 u_dividend_tvalid, u_divisor_tvalid, u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata: same widths and directions for the unsigned divider IP.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN; req_ready = (state==IDLE).
REQ-015 IDLE: req_valid & ~cancel -> latch src1, src2, signed, mod; go to ISSUE. If cancel is high in the same cycle, nothing is latched and the FSM stays in IDLE.
REQ-016 ISSUE: assert dividend and divisor tvalid on the IP selected by the latched signed bit only. Each channel deasserts independently after its tvalid&tready cycle. Go to WAIT once both channels have completed, including completion in the same cycle.
REQ-017 tvalid and tdata stay stable until accepted, even under cancel (AXI-Stream rule). Cancel in ISSUE sets kill_flag; when both channels complete, go to DRAIN instead of WAIT.
REQ-018 WAIT: on the selected dout_tvalid, latch the selected half per DOUT_QHI and go to DONE. Cancel in WAIT -> DRAIN. If cancel and dout_tvalid occur in the same cycle -> IDLE with the result discarded.
REQ-019 DONE: done=1 and result held stable. res_ack or cancel -> IDLE.
REQ-020 DRAIN: done=0. Wait for the selected dout_tvalid, discard the data, then go to IDLE. A new req is not accepted until IDLE is reached.
REQ-021 Latency with no cancel: done rises no earlier than 1 cycle after dout_tvalid. A back-to-back req is accepted the cycle after res_ack.
REQ-022 dout_tvalid from the non-selected IP, or any dout_tvalid while in IDLE or DONE, is ignored.
REQ-023 Divide-by-zero is not an exception; the result is whatever the IP returns, unless REQ-027 applies.

Reset
REQ-024 Asserting reset at any time (mid-ISSUE, WAIT or DRAIN included) forces IDLE asynchronously, and clears kill_flag and the channel-complete flags.
REQ-025 Reset values: all tvalid 0, done 0, busy 0, req_ready 1, result 0, dividend_tdata 0, divisor_tdata 0.
REQ-026 After reset release, the first posedge may accept a req.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN.
- Defined: a req with src2==0 accepted in IDLE goes directly to DONE on the next cycle, with no IP handshake. Result is 0xFFFFFFFF for div and src1 for mod, both signed and unsigned.
- Undefined: zero divisors follow the normal ISSUE/WAIT path.

Verification
REQ-028 Signed div: src1=0xFFFFFFF9 (-7), src2=2, signed=1, mod=0 -> only s_* tvalid asserted. After s_dout_tvalid, done=1 and result=0xFFFFFFFD. result is held until res_ack, then req_ready=1 next cycle.
REQ-029 Unsigned mod: src1=100, src2=7, signed=0, mod=1; u_divisor_tready delayed 3 cycles after u_dividend_tready -> u_dividend_tvalid drops after its handshake, u_divisor_tvalid stays asserted until accepted, and result=2.
REQ-030 Cancel in WAIT, then req_valid asserted the next cycle -> FSM in DRAIN with req_ready=0. The IP result is discarded, done never rises, and the new req is accepted only after IDLE.
REQ-031 Cancel during ISSUE with both treadys low -> tvalid held with unchanged data until accepted, then DRAIN, then IDLE on dout_tvalid; done=0 throughout.
REQ-032 Reset asserted in WAIT, then a stale s_dout_tvalid pulse after reset release -> the pulse is ignored, done=0 and req_ready=1.
REQ-033 DIV_ZERO_FAST_EN defined: src1=0x12345678, src2=0, mod=1 -> done on the next cycle with result=0x12345678 and no tvalid asserted. Undefined: the same stimulus handshakes with the IP.
